// File: rtl/nios2_ocimem_pkg.sv
// Shared types and constants for the Nios II OCI RAM arbiter.
// Contents: FSM state enum, access-owner enum and jdo field bit positions.
package nios2_ocimem_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  typedef enum logic {OWN_JTAG, OWN_AV} owner_t;

  localparam int JDO_W         = 38;
  localparam int JDO_RD_BIT    = 35;
  localparam int JDO_WDATA_MSB = 34;
  localparam int JDO_WDATA_LSB = 3;
  localparam int JDO_ADDR_MSB  = 25;
  localparam int JDO_ADDR_LSB  = 18;

endpackage

// File: rtl/nios2_ocimem_arbiter_if.sv
// Bus bundle between the arbiter and its two requesters.
// JTAG side: jdo payload, the three take_*_ocimem_* pulses, MonDReg,
//   jtag_busy and jtag_overrun.
// Avalon side: av_address, av_read, av_write, av_writedata, av_readdata,
//   av_waitrequest.
// Modports: master = requester side (drives pulses/strobes),
//           slave  = arbiter side.
interface nios2_ocimem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic [37:0]   jdo;
  logic          take_action_ocimem_a;
  logic          take_no_action_ocimem_a;
  logic          take_action_ocimem_b;
  logic [DW-1:0] MonDReg;
  logic          jtag_busy;
  logic          jtag_overrun;

  logic [AW-1:0] av_address;
  logic          av_read;
  logic          av_write;
  logic [DW-1:0] av_writedata;
  logic [DW-1:0] av_readdata;
  logic          av_waitrequest;

  modport master (
    output jdo, take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b,
    input  MonDReg, jtag_busy, jtag_overrun,
    output av_address, av_read, av_write, av_writedata,
    input  av_readdata, av_waitrequest
  );

  modport slave (
    input  jdo, take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b,
    output MonDReg, jtag_busy, jtag_overrun,
    input  av_address, av_read, av_write, av_writedata,
    output av_readdata, av_waitrequest
  );
endinterface

// File: rtl/nios2_ocimem_ram.sv
// Single-port synchronous RAM, 2^AW x DW, registered read data.
// Ports: clk; addr (word address); wdata; we (write enable);
//        q (data at addr, one cycle after addr is sampled).
// Contents are never reset.
module nios2_ocimem_ram #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic          we,
  output logic [DW-1:0] q
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    q <= mem[addr];
  end

endmodule

// File: rtl/nios2_ocimem_arbiter.sv
// Arbitrates the OCI debug RAM between the JTAG debug path and the CPU's
// Avalon debug slave with round-robin fairness. Each access runs
// IDLE -> ISSUE -> DONE, so grants are spaced three cycles apart.
// Ports: clk; reset_n (synchronous, active-low); bus (slave modport of
//        nios2_ocimem_arbiter_if carrying the JTAG and Avalon signals).
// Optional feature: define OCIMEM_AUTOINC_EN to make jtag_addr advance
//        (wrapping) after every completed JTAG read or write.
module nios2_ocimem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  nios2_ocimem_arbiter_if.slave  bus
);
  import nios2_ocimem_pkg::*;

  state_t        state, state_nxt;
  owner_t        owner, last_grant, grant_own;
  logic          grant;

  logic          jp_valid, jp_we;
  logic [DW-1:0] jp_wdata;
  logic [AW-1:0] jtag_addr;
  logic          overrun;
  logic [DW-1:0] mon_d;

  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wdata;
  logic          g_we;
  logic [DW-1:0] ram_q;
  logic          ram_we;

  logic          av_req, av_done, jtag_done;
  logic          jdo_rd;
  logic [AW-1:0] jdo_addr;
  logic [DW-1:0] jdo_wdata;
  logic          slot_free, multi_pulse, any_pulse;
  logic          acc_a, acc_na, acc_b, drop;
  logic          unused_jdo;

  assign jdo_rd     = bus.jdo[JDO_RD_BIT];
  assign jdo_addr   = bus.jdo[JDO_ADDR_MSB:JDO_ADDR_LSB];
  assign jdo_wdata  = bus.jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
  assign unused_jdo = ^{bus.jdo[37:36], bus.jdo[2:0]};

  assign av_req    = bus.av_read | bus.av_write;
  assign av_done   = (state == DONE) && (owner == OWN_AV);
  assign jtag_done = (state == DONE) && (owner == OWN_JTAG);

  // The slot retiring this cycle can take a new pulse in the same cycle.
  assign slot_free   = !jp_valid || jtag_done;
  assign any_pulse   = bus.take_action_ocimem_b | bus.take_action_ocimem_a |
                       bus.take_no_action_ocimem_a;
  assign multi_pulse = (bus.take_action_ocimem_b & bus.take_action_ocimem_a) |
                       (bus.take_action_ocimem_b & bus.take_no_action_ocimem_a) |
                       (bus.take_action_ocimem_a & bus.take_no_action_ocimem_a);

  // Priority _b > action_a > no_action_a; losers and busy-time pulses drop.
  assign acc_b  = slot_free & bus.take_action_ocimem_b;
  assign acc_a  = slot_free & bus.take_action_ocimem_a & ~bus.take_action_ocimem_b;
  assign acc_na = slot_free & bus.take_no_action_ocimem_a &
                  ~bus.take_action_ocimem_a & ~bus.take_action_ocimem_b;
  assign drop   = any_pulse & (~slot_free | multi_pulse);

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_own = OWN_JTAG;
    case (state)
      IDLE: begin
        if (jp_valid || av_req) begin
          grant     = 1'b1;
          state_nxt = ISSUE;
          if (jp_valid && av_req) begin
            grant_own = (last_grant == OWN_AV) ? OWN_JTAG : OWN_AV;
          end else begin
            grant_own = jp_valid ? OWN_JTAG : OWN_AV;
          end
        end
      end
      ISSUE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      owner      <= OWN_AV;
      last_grant <= OWN_AV;
      jp_valid   <= 1'b0;
      jtag_addr  <= '0;
      overrun    <= 1'b0;
      mon_d      <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner      <= grant_own;
        last_grant <= grant_own;
      end
      if (jtag_done) begin
        jp_valid <= 1'b0;
        if (!g_we) begin
          mon_d <= ram_q;
        end
`ifdef OCIMEM_AUTOINC_EN
        jtag_addr <= jtag_addr + 1'b1;
`endif
      end
      // New acceptances override the retirement above.
      if (acc_b) begin
        jp_valid <= 1'b1;
      end
      if (acc_a) begin
        jtag_addr <= jdo_addr;
        if (jdo_rd) begin
          jp_valid <= 1'b1;
        end
      end
      if (acc_na) begin
        jp_valid <= 1'b1;
      end
      if (drop) begin
        overrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (acc_b) begin
      jp_we    <= 1'b1;
      jp_wdata <= jdo_wdata;
    end else if (acc_a || acc_na) begin
      jp_we    <= 1'b0;
    end
    if (grant) begin
      if (grant_own == OWN_JTAG) begin
        g_addr  <= jtag_addr;
        g_wdata <= jp_wdata;
        g_we    <= jp_we;
      end else begin
        g_addr  <= bus.av_address;
        g_wdata <= bus.av_writedata;
        g_we    <= bus.av_write;
      end
    end
  end

  // Write enable is masked by reset so a reset during ISSUE never writes.
  assign ram_we = (state == ISSUE) && g_we && reset_n;

  nios2_ocimem_ram #(.AW(AW), .DW(DW)) u_ram (
    .clk   (clk),
    .addr  (g_addr),
    .wdata (g_wdata),
    .we    (ram_we),
    .q     (ram_q)
  );

  assign bus.MonDReg        = mon_d;
  assign bus.jtag_busy      = jp_valid;
  assign bus.jtag_overrun   = overrun;
  assign bus.av_waitrequest = !av_done;
  assign bus.av_readdata    = av_done ? ram_q : '0;

endmodule

// File: tb/tb_nios2_ocimem_arbiter.sv
// Scoreboard bench for nios2_ocimem_arbiter: drivers push expected
// completions into per-requester queues; a negedge monitor pops and checks
// them whenever av_waitrequest drops or jtag_busy falls.
module tb_nios2_ocimem_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  nios2_ocimem_arbiter_if #(.AW(8), .DW(32)) bus ();

  nios2_ocimem_arbiter #(.AW(8), .DW(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic        rd;
    logic [31:0] data;
    logic [7:0]  lat;
  } exp_t;

  exp_t av_q[$];
  exp_t jt_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam int K_A  = 0;
  localparam int K_NA = 1;
  localparam int K_B  = 2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Monitor: latency counted from the first cycle a strobe / busy is seen.
  initial begin : monitor
    exp_t e;
    logic av_active;
    int   av_cnt;
    logic prev_busy;
    int   b_cnt;
    av_active = 1'b0; av_cnt = 0; prev_busy = 1'b0; b_cnt = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        av_active = 1'b0; prev_busy = 1'b0; b_cnt = 0;
      end else begin
        if (!av_active && (bus.av_read || bus.av_write)) begin
          av_active = 1'b1;
          av_cnt = 0;
        end
        if (av_active) begin
          if (!bus.av_waitrequest) begin
            av_active = 1'b0;
            if (av_q.size() == 0) begin
              n_cmp++; n_bad++;
              $display("FAIL av_unexpected actual=completion required=none");
            end else begin
              e = av_q.pop_front();
              check("av_latency", av_cnt, e.lat);
              if (e.rd) check("av_readdata", bus.av_readdata, e.data);
            end
          end else begin
            av_cnt++;
          end
        end
        if (bus.jtag_busy) begin
          b_cnt++;
        end else if (prev_busy) begin
          if (jt_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL jtag_unexpected actual=completion required=none");
          end else begin
            e = jt_q.pop_front();
            check("jtag_busy_cycles", b_cnt, e.lat);
            if (e.rd) check("MonDReg", bus.MonDReg, e.data);
          end
          b_cnt = 0;
        end
        prev_busy = bus.jtag_busy;
      end
    end
  end

  // Called just after a posedge; the pulse is visible for one cycle.
  task automatic jpulse(input int kind, input logic rd, input logic [7:0] addr,
                        input logic [31:0] wd);
    logic [37:0] j;
    j = '0;
    if (kind == K_A) begin
      j[35] = rd;
      j[25:18] = addr;
      bus.take_action_ocimem_a = 1'b1;
    end else if (kind == K_NA) begin
      bus.take_no_action_ocimem_a = 1'b1;
    end else begin
      j[34:3] = wd;
      bus.take_action_ocimem_b = 1'b1;
    end
    bus.jdo = j;
    @(posedge clk); #1;
    bus.take_action_ocimem_a    = 1'b0;
    bus.take_no_action_ocimem_a = 1'b0;
    bus.take_action_ocimem_b    = 1'b0;
  endtask

  task automatic jwait_idle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!bus.jtag_busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL jtag_timeout actual=busy required=idle");
    end
    @(posedge clk); #1;
  endtask

  // Strobe stays asserted until the done cycle; consecutive calls give a
  // continuous strobe.
  task automatic av_xfer(input logic wr, input logic [7:0] a, input logic [31:0] d,
                         input logic [7:0] lat);
    logic ok;
    exp_t e;
    e.rd = ~wr; e.data = d; e.lat = lat;
    av_q.push_back(e);
    bus.av_address   = a;
    bus.av_writedata = d;
    bus.av_write     = wr;
    bus.av_read      = ~wr;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!bus.av_waitrequest) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL av_timeout actual=waitrequest_high required=completion");
    end
    @(posedge clk); #1;
    bus.av_read  = 1'b0;
    bus.av_write = 1'b0;
  endtask

  function automatic exp_t mk(input logic rd, input logic [31:0] d, input logic [7:0] lat);
    exp_t e;
    e.rd = rd; e.data = d; e.lat = lat;
    return e;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [31:0] second_rd;
    bus.jdo = '0;
    bus.take_action_ocimem_a = 1'b0;
    bus.take_no_action_ocimem_a = 1'b0;
    bus.take_action_ocimem_b = 1'b0;
    bus.av_address = '0;
    bus.av_read = 1'b0;
    bus.av_write = 1'b0;
    bus.av_writedata = '0;

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_waitrequest", bus.av_waitrequest, 32'd1);
    check("rst_MonDReg", bus.MonDReg, 32'd0);
    check("rst_jtag_busy", bus.jtag_busy, 32'd0);
    check("rst_jtag_overrun", bus.jtag_overrun, 32'd0);
    check("rst_av_readdata", bus.av_readdata, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // JTAG write then read of 0x10
    jpulse(K_A, 1'b0, 8'h10, 32'h0);
    jt_q.push_back(mk(1'b0, 32'h0, 8'd3));
    jpulse(K_B, 1'b0, 8'h00, 32'hDEADBEEF);
    jwait_idle();
    jt_q.push_back(mk(1'b1, 32'hDEADBEEF, 8'd3));
    jpulse(K_A, 1'b1, 8'h10, 32'h0);
    jwait_idle();

    // Avalon write then read of 0x20
    av_xfer(1'b1, 8'h20, 32'h12345678, 8'd2);
    av_xfer(1'b0, 8'h20, 32'h12345678, 8'd2);
    @(posedge clk); #1;

    // Overrun: second _b one cycle after the first is dropped
    @(negedge clk);
    check("overrun_before", bus.jtag_overrun, 32'd0);
    @(posedge clk); #1;
    jpulse(K_A, 1'b0, 8'h30, 32'h0);
    jt_q.push_back(mk(1'b0, 32'h0, 8'd3));
    jpulse(K_B, 1'b0, 8'h00, 32'h11111111);
    jpulse(K_B, 1'b0, 8'h00, 32'h22222222);
    @(negedge clk);
    check("overrun_set", bus.jtag_overrun, 32'd1);
    jwait_idle();
    jt_q.push_back(mk(1'b1, 32'h11111111, 8'd3));
    jpulse(K_A, 1'b1, 8'h30, 32'h0);
    jwait_idle();
    av_xfer(1'b0, 8'h30, 32'h11111111, 8'd2);

    // Address wrap / auto-increment
    av_xfer(1'b1, 8'hFF, 32'hAAAA00FF, 8'd2);
    av_xfer(1'b1, 8'h00, 32'hBBBB0000, 8'd2);
    @(posedge clk); #1;
    jpulse(K_A, 1'b0, 8'hFF, 32'h0);
    jt_q.push_back(mk(1'b1, 32'hAAAA00FF, 8'd3));
    jpulse(K_NA, 1'b0, 8'h00, 32'h0);
    jwait_idle();
`ifdef OCIMEM_AUTOINC_EN
    second_rd = 32'hBBBB0000;
`else
    second_rd = 32'hAAAA00FF;
`endif
    jt_q.push_back(mk(1'b1, second_rd, 8'd3));
    jpulse(K_NA, 1'b0, 8'h00, 32'h0);
    jwait_idle();

    // Fresh reset so the first tie goes to JTAG
    do_reset();
    @(negedge clk);
    check("rst2_overrun", bus.jtag_overrun, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Contention: continuous Avalon reads vs two JTAG reads; grants J,A,J,A
    jt_q.push_back(mk(1'b1, 32'hDEADBEEF, 8'd3));
    jt_q.push_back(mk(1'b1, 32'hDEADBEEF, 8'd5));
    fork
      begin
        jpulse(K_A, 1'b1, 8'h10, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        jpulse(K_A, 1'b1, 8'h10, 32'h0);
      end
      begin
        @(posedge clk); #1;
        av_xfer(1'b0, 8'h20, 32'h12345678, 8'd5);
        av_xfer(1'b0, 8'h20, 32'h12345678, 8'd5);
      end
    join

    repeat (6) @(posedge clk);
    #1;
    check("av_queue_left", av_q.size(), 32'd0);
    check("jtag_queue_left", jt_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nios2_ocimem_arbiter.md
# nios2_ocimem_arbiter

Arbitrates the Nios II on-chip debug memory (OCI RAM) between the JTAG debug path and the CPU's Avalon debug slave. It sits in the `clk` domain after the debug module's sysclk logic and consumes its `take_action_ocimem_*` pulses and `jdo` payload. It sequences single-port RAM accesses with round-robin fairness and returns JTAG read data on `MonDReg`.

## Interface
Parameters:
- `AW`, 8: OCI RAM word-address width (2^AW words).
- `DW`, 32: data width; `jdo` field placement requires 32.

Ports:
- `clk`  in  1  system clock; sole clock.
- `reset_n`  in  1  reset, synchronous, active-low.
- `jdo`  in  38  JTAG payload; addr = `jdo[25:18]`, rd-flag = `jdo[35]`, wdata = `jdo[34:3]`.
- `take_action_ocimem_a`  in  1  pulse; load `jtag_addr`; if `jdo[35]`=1, also request a read.
- `take_no_action_ocimem_a`  in  1  pulse; request a read at the current `jtag_addr`.
- `take_action_ocimem_b`  in  1  pulse; request a write of wdata at `jtag_addr`.
- `MonDReg`  out  DW  last JTAG read data.
- `jtag_busy`  out  1  JTAG request pending or in flight.
- `jtag_overrun`  out  1  sticky; a JTAG pulse arrived while busy.
- `av_address`  in  AW  Avalon word address.
- `av_read`, `av_write`  in  1  Avalon strobes; held until waitrequest is low.
- `av_writedata`  in  DW  Avalon write data.
- `av_readdata`  out  DW  valid in the cycle `av_waitrequest`=0 for a read.
- `av_waitrequest`  out  1  Avalon stall.

## Operation
- JTAG pulses are registered into a depth-1 pending slot: `jp_valid`, `jp_we`, `jp_wdata`. `take_action_ocimem_a` updates `jtag_addr` immediately, even when no read is requested.
- Any JTAG pulse while `jtag_busy`=1 is dropped. The drop sets `jtag_overrun` and leaves `jtag_addr` unchanged.
- A pulse in the same cycle the pending slot retires (DONE) is accepted, not an overrun.
- If more than one pulse arrives in a cycle, priority is `_b` > `action_a` > `no_action_a`. The losers count as an overrun.
- Avalon request = `av_read | av_write`. Both strobes high together is treated as a write.
- FSM states are IDLE, ISSUE and DONE.
- IDLE: if any request, pick the winner and register addr, data, we and owner, then go to ISSUE. Otherwise stay in IDLE.
- Winner selection: with one requester, that requester wins. With both, the requester not in `last_grant` wins. `last_grant` updates on each grant.
- ISSUE: the RAM samples the address, write data and we. The next state is always DONE.
- DONE for an AV owner: `av_waitrequest`=0 for exactly this cycle. `av_readdata` = RAM q.
- DONE for a JTAG owner: if read, `MonDReg` <= RAM q; clear `jp_valid`; apply auto-increment.
- DONE always returns to IDLE. Back-to-back grants are therefore spaced 3 cycles apart.
- Reset values: `MonDReg`=0, `jtag_busy`=0, `jtag_overrun`=0, `av_waitrequest`=1, `av_readdata`=0, `jtag_addr`=0, state=IDLE, `last_grant`=AV (so JTAG wins the first tie).
- Reset mid-operation: the FSM goes to IDLE and the pending slot is cleared. RAM write enable is gated by `reset_n`, so no write occurs in a reset cycle. RAM contents are not reset.

## Timing
- Avalon: strobe visible in IDLE at cycle 0 → waitrequest low at cycle 2; read data is valid in cycle 2.
- JTAG: pulse at cycle 0 → pending at 1 → granted at 1 → DONE at 3 → `MonDReg` updated, visible at cycle 4. `jtag_busy` is high in cycles 1–3.
- Worst-case JTAG wait under continuous Avalon load: one Avalon transfer, i.e. 3 cycles extra.

## Configuration
- `OCIMEM_AUTOINC_EN` defined: `jtag_addr` increments after every completed JTAG read or write, wrapping from 2^AW−1 to 0.
- Not defined: `jtag_addr` changes only via `take_action_ocimem_a`.

## Structure
- Package `nios2_ocimem_pkg`:
  - FSM state enum `{IDLE, ISSUE, DONE}`.
  - Owner enum `{OWN_JTAG, OWN_AV}`.
  - `jdo` field bit-position constants.
- Sub-module `nios2_ocimem_ram`: single-port synchronous RAM (2^AW × DW) with registered read and write enable.

## Test plan
- Reset: hold `reset_n`=0 for 2 cycles → `av_waitrequest`=1, `MonDReg`=0, `jtag_busy`=0, `jtag_overrun`=0.
- JTAG write/read:
  - `action_a` with addr 0x10, `jdo[35]`=0; then `_b` with wdata 0xDEADBEEF.
  - Then `action_a` with addr 0x10, `jdo[35]`=1.
  - Required: `MonDReg`=0xDEADBEEF 4 cycles after the last pulse.
- Avalon read: write 0x12345678 at 0x20 via Avalon, then read 0x20 → waitrequest low in cycle 2 of each transfer; `av_readdata`=0x12345678.
- Contention:
  - `av_read` held continuously while a JTAG read is pulsed.
  - Required: grants alternate and the first tie goes to JTAG.
- Overrun: second `_b` pulse 1 cycle after the first → `jtag_overrun`=1; the RAM holds the first data only.
- Auto-increment: with `OCIMEM_AUTOINC_EN`, load addr 0xFF, then two `no_action_a` reads spaced ≥4 cycles → reads from 0xFF then 0x00. Without the macro, both reads are from 0xFF.
